// File: rtl/ysyx_25040111_csr_pkg.sv
// Purpose : shared CSR addresses, mstatus layout and write-mask helpers for the csr file.
// Latency : n/a (package: constants and pure functions only).
// Backpressure: n/a.
// Contents: CSR_* addresses, MSTATUS_MIE/MPIE bit indices, MSTATUS_WMASK, MSTATUS_RESET,
//           csr_implemented / csr_writable / csr_wmask helpers.
package ysyx_25040111_csr_pkg;

  localparam int CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [CSR_AW-1:0] CSR_MEPC      = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [CSR_AW-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [CSR_AW-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [CSR_AW-1:0] CSR_MVENDORID = 12'hF11;
  localparam logic [CSR_AW-1:0] CSR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // Only MIE and MPIE are software-writable; MPP reads back as M-mode forever.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

  function automatic logic csr_implemented(input logic [CSR_AW-1:0] addr,
                                           input logic has_cycle);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MVENDORID, CSR_MARCHID:  return 1'b1;
      CSR_MCYCLE, CSR_MCYCLEH:     return has_cycle;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic logic csr_writable(input logic [CSR_AW-1:0] addr,
                                        input logic has_cycle);
    return csr_implemented(addr, has_cycle) &&
           (addr != CSR_MVENDORID) && (addr != CSR_MARCHID);
  endfunction

  // Value a write actually stores, so forwarding and the register agree.
  function automatic logic [31:0] csr_wmask(input logic [CSR_AW-1:0] addr,
                                            input logic [31:0] data);
    case (addr)
      CSR_MSTATUS:          return (data & MSTATUS_WMASK) | MSTATUS_RESET;
      CSR_MTVEC, CSR_MEPC:  return data & ~32'h3;
      default:              return data;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25040111_csr_file_if.sv
// Purpose : bundle of CSR access, trap/mret commit and redirect signals between EXU and csr file.
// Latency : n/a (wires only); rdata/illegal combinational, redirect/redirect_pc registered in the csr file.
// Backpressure: none; every strobe is accepted in the cycle it is asserted.
// Ports   : master = core side (drives wen/waddr/wdata/ren/raddr/trap_*/mret),
//           slave  = csr file (drives rdata/illegal/redirect/redirect_pc).
interface ysyx_25040111_csr_file_if
  import ysyx_25040111_csr_pkg::*;
#(
  parameter int XLEN = 32
);
  logic              wen;
  logic [CSR_AW-1:0] waddr;
  logic [XLEN-1:0]   wdata;
  logic              ren;
  logic [CSR_AW-1:0] raddr;
  logic [XLEN-1:0]   rdata;
  logic              illegal;
  logic              trap_valid;
  logic [XLEN-1:0]   trap_cause;
  logic [XLEN-1:0]   trap_pc;
  logic              mret;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output wen, waddr, wdata, ren, raddr, trap_valid, trap_cause, trap_pc, mret,
    input  rdata, illegal, redirect, redirect_pc
  );

  modport slave (
    input  wen, waddr, wdata, ren, raddr, trap_valid, trap_cause, trap_pc, mret,
    output rdata, illegal, redirect, redirect_pc
  );

endinterface

// File: rtl/ysyx_25040111_csr_cycle.sv
// Purpose : free-running 64-bit cycle counter with independent low/high word load.
// Latency : load visible the cycle after the strobe; otherwise +1 every cycle out of reset.
// Backpressure: none.
// Ports   : clock, reset (sync active-low), load_lo/load_hi strobes, wdata load value, value 64-bit count.
module ysyx_25040111_csr_cycle (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  // A load replaces the increment for that cycle; the untouched half holds,
  // so a low-word load also swallows any carry into the high word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      value <= '0;
    end else if (load_lo) begin
      value[31:0] <= wdata;
    end else if (load_hi) begin
      value[63:32] <= wdata;
    end else begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_25040111_csr_file.sv
// Purpose : machine-mode CSR file (mstatus/mtvec/mepc/mcause/mscratch/mcycle) with atomic trap entry and mret.
// Latency : rdata/illegal combinational with same-cycle write forwarding; redirect/redirect_pc one cycle after trap/mret.
// Backpressure: none; priority trap_valid > mret > wen, the losing write is dropped.
// Ports   : clock, reset (sync active-low), bus (slave modport of ysyx_25040111_csr_file_if).
module ysyx_25040111_csr_file
  import ysyx_25040111_csr_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MVENDORID = 32'h7973_7978,
  parameter logic [31:0] MARCHID   = 32'd25040111,
  parameter bit          HAS_CYCLE = 1'b1
) (
  input logic                       clock,
  input logic                       reset,
  ysyx_25040111_csr_file_if.slave   bus
);

  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mscratch_q;
  logic [63:0]     mcycle;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            wr_en;
  logic [XLEN-1:0] wr_val;
  logic [XLEN-1:0] rd_val;

  // A software write only lands when no trap/mret owns the cycle and the target is writable.
  assign wr_en  = bus.wen && !bus.trap_valid && !bus.mret && csr_writable(bus.waddr, HAS_CYCLE);
  assign wr_val = csr_wmask(bus.waddr, bus.wdata);

  generate
    if (HAS_CYCLE) begin : g_cycle
      logic load_lo;
      logic load_hi;
      assign load_lo = wr_en && (bus.waddr == CSR_MCYCLE);
      assign load_hi = wr_en && (bus.waddr == CSR_MCYCLEH);
      ysyx_25040111_csr_cycle u_cycle (
        .clock   (clock),
        .reset   (reset),
        .load_lo (load_lo),
        .load_hi (load_hi),
        .wdata   (wr_val),
        .value   (mcycle)
      );
    end else begin : g_no_cycle
      assign mcycle = '0;
    end
  endgenerate

  always_comb begin
    rd_val = '0;
    case (bus.raddr)
      CSR_MSTATUS:   rd_val = mstatus_q;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MCYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH:   rd_val = mcycle[63:32];
      CSR_MVENDORID: rd_val = MVENDORID;
      CSR_MARCHID:   rd_val = MARCHID;
      default:       rd_val = '0;
    endcase
  end

  // Forwarding uses the masked value so a read-after-write in the same cycle
  // matches what the register will hold next cycle.
  assign bus.rdata = !bus.ren ? '0 :
                     (wr_en && (bus.raddr == bus.waddr)) ? wr_val : rd_val;

  assign bus.illegal = (bus.ren && !csr_implemented(bus.raddr, HAS_CYCLE)) ||
                       (bus.wen && !csr_writable(bus.waddr, HAS_CYCLE));

  always_ff @(posedge clock) begin
    if (!reset) begin
      mstatus_q     <= MSTATUS_RESET;
      mtvec_q       <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mscratch_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= bus.trap_valid || bus.mret;
      if (bus.trap_valid) begin
        // Redirect target is the handler base as it stood before this cycle.
        redirect_pc_q             <= mtvec_q;
        mepc_q                    <= bus.trap_pc & {{(XLEN-2){1'b1}}, 2'b00};
        mcause_q                  <= bus.trap_cause;
        mstatus_q[MSTATUS_MPIE]   <= mstatus_q[MSTATUS_MIE];
        mstatus_q[MSTATUS_MIE]    <= 1'b0;
      end else if (bus.mret) begin
        redirect_pc_q             <= mepc_q;
        mstatus_q[MSTATUS_MIE]    <= mstatus_q[MSTATUS_MPIE];
        mstatus_q[MSTATUS_MPIE]   <= 1'b1;
      end else if (wr_en) begin
        case (bus.waddr)
          CSR_MSTATUS:  mstatus_q  <= wr_val;
          CSR_MTVEC:    mtvec_q    <= wr_val;
          CSR_MSCRATCH: mscratch_q <= wr_val;
          CSR_MEPC:     mepc_q     <= wr_val;
          CSR_MCAUSE:   mcause_q   <= wr_val;
          default:      ;
        endcase
      end
    end
  end

  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

endmodule
